// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: host-side request and read-response bundle for sram_ctrl.
// req_be is present only when SRAM_CTRL_BE_EN is defined.
interface sram_ctrl_if #(
    parameter int AW = 18,
    parameter int DW = 16
);
`ifdef SRAM_CTRL_BE_EN
    localparam int NB = DW / 8;
`endif

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
`ifdef SRAM_CTRL_BE_EN
    logic [NB-1:0] req_be;
`endif
    logic          rd_valid;
    logic [DW-1:0] rd_data;

`ifdef SRAM_CTRL_BE_EN
    modport master (output req_valid, req_we, req_addr, req_wdata, req_be,
                    input  req_ready, rd_valid, rd_data);
    modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_be,
                    output req_ready, rd_valid, rd_data);
`else
    modport master (output req_valid, req_we, req_addr, req_wdata,
                    input  req_ready, rd_valid, rd_data);
    modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                    output req_ready, rd_valid, rd_data);
`endif
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: asynchronous SRAM controller, one access at a time with fixed-length strobes.
// Optional byte-lane enables (req_be / be_n) under macro SRAM_CTRL_BE_EN.
module sram_ctrl #(
    parameter int AW       = 18,
    parameter int DW       = 16,
    parameter int WAIT_CYC = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    sram_ctrl_if.slave    host,
    output logic [AW-1:0] ad,
    output logic          ce_a_n,
    output logic          oe_n,
    output logic          we_n,
`ifdef SRAM_CTRL_BE_EN
    output logic [DW/8-1:0] be_n,
`endif
    inout  wire  [DW-1:0] dio_a
);
`ifdef SRAM_CTRL_BE_EN
    localparam int NB = DW / 8;
`endif
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_ACC   = 3'd1;
    localparam logic [2:0] WR_SETUP = 3'd2;
    localparam logic [2:0] WR_PULSE = 3'd3;
    localparam logic [2:0] WR_HOLD  = 3'd4;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

    logic [2:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] ad_q, ad_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          ce_n_q, ce_n_d;
    logic          oe_n_q, oe_n_d;
    logic          we_n_q, we_n_d;
    logic          drv_q, drv_d;
`ifdef SRAM_CTRL_BE_EN
    logic [NB-1:0] be_q, be_d;
    logic [NB-1:0] be_n_q, be_n_d;
`endif

    // Sequencer: accept in IDLE, count the strobe length, capture read data at the end of access.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ad_d       = ad_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
`ifdef SRAM_CTRL_BE_EN
        be_d       = be_q;
`endif
        case (state_q)
            IDLE: begin
                if (host.req_valid) begin
                    ad_d    = host.req_addr;
                    wdata_d = host.req_wdata;
`ifdef SRAM_CTRL_BE_EN
                    be_d    = host.req_be;
`endif
                    if (host.req_we) begin
                        state_d = WR_SETUP;
                    end else begin
                        state_d = RD_ACC;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_ACC: begin
                if (cnt_q == 4'd0) begin
                    state_d    = IDLE;
                    rd_data_d  = dio_a;
                    rd_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = CNT_LOAD;
            end
            WR_PULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pin decode from the next state so every SRAM strobe and the bus enable leave a flop.
    always_comb begin
        ce_n_d = (state_d == IDLE);
        oe_n_d = (state_d != RD_ACC);
        we_n_d = (state_d != WR_PULSE);
        drv_d  = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
`ifdef SRAM_CTRL_BE_EN
        case (state_d)
            RD_ACC:                     be_n_d = {NB{1'b0}};
            WR_SETUP, WR_PULSE, WR_HOLD: be_n_d = ~be_d;
            default:                    be_n_d = {NB{1'b1}};
        endcase
`endif
    end

    // State and pin registers; reset parks the SRAM deselected with the bus released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            ad_q       <= {AW{1'b0}};
            wdata_q    <= {DW{1'b0}};
            rd_data_q  <= {DW{1'b0}};
            rd_valid_q <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            drv_q      <= 1'b0;
`ifdef SRAM_CTRL_BE_EN
            be_q       <= {NB{1'b0}};
            be_n_q     <= {NB{1'b1}};
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ad_q       <= ad_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            drv_q      <= drv_d;
`ifdef SRAM_CTRL_BE_EN
            be_q       <= be_d;
            be_n_q     <= be_n_d;
`endif
        end
    end

    assign host.req_ready = (state_q == IDLE);
    assign host.rd_valid  = rd_valid_q;
    assign host.rd_data   = rd_data_q;
    assign ad             = ad_q;
    assign ce_a_n         = ce_n_q;
    assign oe_n           = oe_n_q;
    assign we_n           = we_n_q;
`ifdef SRAM_CTRL_BE_EN
    assign be_n           = be_n_q;
`endif
    assign dio_a          = drv_q ? wdata_q : {DW{1'bz}};
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed and random checks of sram_ctrl against behavioural SRAM models.
module tb_sram_ctrl;
    localparam int AW  = 18, DW  = 16, WC  = 2,  NB  = DW / 8;
    localparam int AW2 = 20, DW2 = 32, WC2 = 15, NB2 = DW2 / 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0, n_pass = 0, n_fail = 0, cyc = 0, conflicts = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT 1: default configuration
    sram_ctrl_if #(.AW(AW), .DW(DW)) bus ();
    wire  [DW-1:0] dio;
    logic [AW-1:0] ad;
    logic          ce_n, oe_n, we_n;
    logic [NB-1:0] lane1;
`ifdef SRAM_CTRL_BE_EN
    logic [NB-1:0] be_n;
    assign lane1 = ~be_n;
`else
    assign lane1 = {NB{1'b1}};
`endif
    sram_ctrl #(.AW(AW), .DW(DW), .WAIT_CYC(WC)) dut (
        .clk(clk), .rst_n(rst_n), .host(bus), .ad(ad),
        .ce_a_n(ce_n), .oe_n(oe_n), .we_n(we_n),
`ifdef SRAM_CTRL_BE_EN
        .be_n(be_n),
`endif
        .dio_a(dio));

    // DUT 2: long strobes, wide bus
    sram_ctrl_if #(.AW(AW2), .DW(DW2)) bus2 ();
    wire  [DW2-1:0] dio2;
    logic [AW2-1:0] ad2;
    logic           ce2_n, oe2_n, we2_n;
    logic [NB2-1:0] lane2;
`ifdef SRAM_CTRL_BE_EN
    logic [NB2-1:0] be2_n;
    assign lane2 = ~be2_n;
`else
    assign lane2 = {NB2{1'b1}};
`endif
    sram_ctrl #(.AW(AW2), .DW(DW2), .WAIT_CYC(WC2)) dut2 (
        .clk(clk), .rst_n(rst_n), .host(bus2), .ad(ad2),
        .ce_a_n(ce2_n), .oe_n(oe2_n), .we_n(we2_n),
`ifdef SRAM_CTRL_BE_EN
        .be_n(be2_n),
`endif
        .dio_a(dio2));

    // Behavioural SRAMs
    logic [DW-1:0]  mem  [0:255];
    logic [DW2-1:0] mem2 [0:63];
    assign dio  = (!ce_n  && !oe_n)  ? mem[ad[7:0]]   : {DW{1'bz}};
    assign dio2 = (!ce2_n && !oe2_n) ? mem2[ad2[5:0]] : {DW2{1'bz}};
    always @(posedge clk) begin
        if (!ce_n && !we_n)
            for (int b = 0; b < NB; b++)
                if (lane1[b]) mem[ad[7:0]][b*8 +: 8] <= dio[b*8 +: 8];
        if (!ce2_n && !we2_n)
            for (int b = 0; b < NB2; b++)
                if (lane2[b]) mem2[ad2[5:0]][b*8 +: 8] <= dio2[b*8 +: 8];
    end

    // Scoreboard state
    logic [DW-1:0]  sh1 [0:255];
    logic [DW2-1:0] sh2 [0:63];
    bit             written2 [0:63];
    logic [DW-1:0]  q1 [$];
    logic [DW2-1:0] q2 [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Read-response monitors pop the scoreboard
    always @(negedge clk) begin
        if (rst_n && bus.rd_valid) begin
            if (q1.size() == 0) chk("rd_valid_unexpected", 64'(bus.rd_valid), 64'd0);
            else                chk("rd_data", 64'(bus.rd_data), 64'(q1.pop_front()));
        end
        if (rst_n && bus2.rd_valid) begin
            if (q2.size() == 0) chk("rd_valid2_unexpected", 64'(bus2.rd_valid), 64'd0);
            else                chk("rd_data2", 64'(bus2.rd_data), 64'(q2.pop_front()));
        end
        if (!oe_n && (dio !== mem[ad[7:0]]))     conflicts++;
        if (!oe2_n && (dio2 !== mem2[ad2[5:0]])) conflicts++;
    end

    task automatic op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [NB-1:0] be, input bit push, output int acc);
        int n;
        logic [NB-1:0] m;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
`ifdef SRAM_CTRL_BE_EN
        bus.req_be = be;
        m = be;
`else
        m = {NB{1'b1}} | be;
`endif
        n = 0;
        while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("accept_timeout", 64'(bus.req_ready), 64'd1);
        acc = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (we) begin
            for (int b = 0; b < NB; b++) if (m[b]) sh1[a[7:0]][b*8 +: 8] = d[b*8 +: 8];
        end else if (push) begin
            q1.push_back(sh1[a[7:0]]);
        end
    endtask

    task automatic op2(input logic we, input logic [AW2-1:0] a, input logic [DW2-1:0] d);
        int n;
        bus2.req_valid = 1'b1; bus2.req_we = we; bus2.req_addr = a; bus2.req_wdata = d;
        n = 0;
        while (!bus2.req_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("accept2_timeout", 64'(bus2.req_ready), 64'd1);
        @(negedge clk);
        bus2.req_valid = 1'b0;
        if (we) sh2[a[5:0]] = d;
        else    q2.push_back(sh2[a[5:0]]);
    endtask

    initial begin
        int a0, a1, a2, we_lo, rdy_lo, drv, rdv_at, oe_lo, bad, last_oe, first_drv, n;
        bit pend;
        rst_n = 1'b0;
        bus.req_valid  = 1'b0; bus.req_we  = 1'b0; bus.req_addr  = '0; bus.req_wdata  = '0;
        bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
`ifdef SRAM_CTRL_BE_EN
        bus.req_be = {NB{1'b1}}; bus2.req_be = {NB2{1'b1}};
`endif
        repeat (3) @(negedge clk);
        chk("rst_ce_n", 64'(ce_n), 64'd1);
        chk("rst_oe_n", 64'(oe_n), 64'd1);
        chk("rst_we_n", 64'(we_n), 64'd1);
        chk("rst_ad", 64'(ad), 64'd0);
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
        chk("rst_ce2_n", 64'(ce2_n), 64'd1);
`ifdef SRAM_CTRL_BE_EN
        chk("rst_be_n", 64'(be_n), 64'(2'b11));
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(bus.req_ready), 64'd1);

        // Write 0x00010 <- 0xA5C3
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 18'h00010; bus.req_wdata = 16'hA5C3;
        @(negedge clk);
        bus.req_valid = 1'b0;
        sh1[8'h10] = 16'hA5C3;
        chk("setup_ce_n", 64'(ce_n), 64'd0);
        chk("setup_we_n", 64'(we_n), 64'd1);
        chk("setup_ad", 64'(ad), 64'h10);
        we_lo = 0; rdy_lo = 0; drv = 0;
        for (int k = 0; k < 6; k++) begin
            if (!we_n) we_lo++;
            if (!bus.req_ready) rdy_lo++;
            if (oe_n && dio === 16'hA5C3) drv++;
            @(negedge clk);
        end
        chk("we_low_cycles", 64'(we_lo), 64'(WC));
        chk("ready_low_cycles", 64'(rdy_lo), 64'(WC + 2));
        chk("dio_drive_cycles", 64'(drv), 64'(WC + 2));

        // Read 0x00010: latency and strobe length
        op(1'b0, 18'h00010, 16'h0, {NB{1'b1}}, 1'b1, a0);
        rdv_at = -1; oe_lo = 0;
        for (int k = 1; k <= 5; k++) begin
            if (!oe_n) oe_lo++;
            if (bus.rd_valid && rdv_at < 0) rdv_at = k;
            @(negedge clk);
        end
        chk("rd_latency", 64'(rdv_at), 64'(WC + 1));
        chk("oe_low_cycles", 64'(oe_lo), 64'(WC));

        // No request: controller stays idle, address held
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (!ce_n || !bus.req_ready) bad++;
            @(negedge clk);
        end
        chk("idle_no_strobe", 64'(bad), 64'd0);
        chk("idle_ad_held", 64'(ad), 64'h10);

        // Read followed by write with req_valid held
        op(1'b1, 18'h00020, 16'h0F0F, {NB{1'b1}}, 1'b0, a0);
        op(1'b0, 18'h00020, 16'h0, {NB{1'b1}}, 1'b1, a0);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 18'h00020; bus.req_wdata = 16'hF0F0;
        last_oe = -1; first_drv = -1; bad = 0; pend = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (pend) bus.req_valid = 1'b0;
            if (!oe_n) last_oe = k;
            if (oe_n && dio === 16'hF0F0 && first_drv < 0) first_drv = k;
            if (!oe_n && dio === 16'hF0F0) bad++;
            pend = bus.req_valid && bus.req_ready;
            @(negedge clk);
        end
        sh1[8'h20] = 16'hF0F0;
        chk("rd_wr_turnaround_gap", 64'(first_drv - last_oe - 1), 64'd1);
        chk("oe_with_drive", 64'(bad), 64'd0);
        op(1'b0, 18'h00020, 16'h0, {NB{1'b1}}, 1'b1, a0);

        // Back-to-back throughput
        op(1'b1, 18'h00030, 16'h1111, {NB{1'b1}}, 1'b0, a0);
        op(1'b1, 18'h00031, 16'h2222, {NB{1'b1}}, 1'b0, a1);
        op(1'b1, 18'h00032, 16'h3333, {NB{1'b1}}, 1'b0, a2);
        chk("wr_spacing_1", 64'(a1 - a0), 64'(WC + 3));
        chk("wr_spacing_2", 64'(a2 - a1), 64'(WC + 3));
        op(1'b0, 18'h00030, 16'h0, {NB{1'b1}}, 1'b1, a0);
        op(1'b0, 18'h00031, 16'h0, {NB{1'b1}}, 1'b1, a1);
        op(1'b0, 18'h00032, 16'h0, {NB{1'b1}}, 1'b1, a2);
        chk("rd_spacing_1", 64'(a1 - a0), 64'(WC + 1));
        chk("rd_spacing_2", 64'(a2 - a1), 64'(WC + 1));

        // Partial write
        op(1'b1, 18'h00005, 16'hFFFF, 2'b11, 1'b0, a0);
        op(1'b1, 18'h00005, 16'h1234, 2'b01, 1'b0, a0);
`ifdef SRAM_CTRL_BE_EN
        chk("wr_be_n", 64'(be_n), 64'(2'b10));
`endif
        op(1'b0, 18'h00005, 16'h0, 2'b11, 1'b1, a0);
`ifdef SRAM_CTRL_BE_EN
        chk("rd_be_n", 64'(be_n), 64'(2'b00));
        chk("model_be_merge", 64'(sh1[8'h05]), 64'hFF34);
`else
        chk("model_full_write", 64'(sh1[8'h05]), 64'h1234);
`endif

        // Reset in the second access cycle of a read
        op(1'b0, 18'h00010, 16'h0, {NB{1'b1}}, 1'b0, a0);
        @(posedge clk); #1;
        chk("abort_in_access", 64'(oe_n), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_ce_n", 64'(ce_n), 64'd1);
        chk("abort_oe_n", 64'(oe_n), 64'd1);
        chk("abort_we_n", 64'(we_n), 64'd1);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 18'h00010;
        repeat (3) @(negedge clk);
        chk("rst_ignores_req", 64'(ce_n), 64'd1);
        chk("abort_rd_data", 64'(bus.rd_data), 64'd0);
        rst_n = 1'b1;
        chk("abort_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        chk("accept_first_edge", 64'(oe_n), 64'd0);
        q1.push_back(sh1[8'h10]);
        @(negedge clk);
        bus.req_valid = 1'b0;

        // Random traffic on the wide, slow instance
        for (int i = 0; i < 100; i++) begin
            int  idx;
            bit  w;
            idx = $urandom_range(0, 15);
            w   = ($urandom_range(0, 1) == 1) || !written2[idx];
            written2[idx] = 1'b1;
            op2(w, {14'h2B3C, 6'(idx)}, DW2'($urandom));
        end

        n = 0;
        while ((q1.size() > 0 || q2.size() > 0) && n < 400) begin @(negedge clk); n++; end
        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q2_drained", 64'(q2.size()), 64'd0);
        chk("oe_drive_conflicts", 64'(conflicts), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter AW, default 18: SRAM and request address width in bits.
REQ-002 Parameter DW, default 16: data width in bits; SHALL be a multiple of 8; NB = DW/8 byte lanes.
REQ-003 Parameter WAIT_CYC, default 2: access-strobe length in clocks; legal range 1..15.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  host request present.
REQ-007 req_ready  output  1  controller can accept a request.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  AW  word address.
REQ-010 req_wdata  input  DW  write data.
REQ-011 req_be  input  NB  write byte enables, active-high; present only with SRAM_CTRL_BE_EN.
REQ-012 rd_valid  output  1  one-cycle pulse marking valid rd_data.
REQ-013 rd_data  output  DW  read data, held until the next read completes.
REQ-014 ad  output  AW  SRAM address.
REQ-015 ce_a_n, oe_n, we_n  output  1 each  SRAM chip select, output enable and write enable, active-low.
REQ-016 be_n  output  NB  SRAM byte-lane enables, active-low; present only with SRAM_CTRL_BE_EN.
REQ-017 dio_a  inout  DW  bidirectional SRAM data bus.

Function
REQ-018 States: IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge with req_valid && req_ready, and the address, data and byte enables are registered on that edge.
REQ-020 Accepted read: IDLE -> RD_ACC for WAIT_CYC cycles with ce_a_n=0, oe_n=0, we_n=1; dio_a is captured at the edge ending the last RD_ACC cycle; rd_valid=1 for the following cycle (IDLE); total latency = WAIT_CYC+1 clocks from accept to rd_valid.
REQ-021 Accepted write: WR_SETUP 1 cycle (ce_a_n=0, we_n=1, dio_a driven), then WR_PULSE WAIT_CYC cycles (we_n=0), then WR_HOLD 1 cycle (we_n=1, ce_a_n=0, dio_a still driven), then IDLE; occupancy = WAIT_CYC+2 clocks.
REQ-022 dio_a SHALL be driven only in WR_SETUP, WR_PULSE and WR_HOLD; otherwise high-Z.
REQ-023 oe_n SHALL never be 0 while dio_a is driven; at least one IDLE cycle (oe_n=1) SHALL separate RD_ACC from WR_SETUP.
REQ-024 ad, ce_a_n, oe_n, we_n, be_n and the dio_a enable SHALL come directly from flops.
REQ-025 In IDLE: ce_a_n=1, oe_n=1, we_n=1, ad holds its last value.
REQ-026 req_valid deasserted in IDLE: no state change and no SRAM strobes.
REQ-027 Back-to-back requests are serviced at one per (occupancy + 1 IDLE) cycles with no request lost or duplicated.
REQ-028 An unused or out-of-range WAIT_CYC value is a configuration error; behaviour outside the range 1..15 is not defined.

Reset
REQ-029 While rst_n=0: state=IDLE, ce_a_n=1, oe_n=1, we_n=1, be_n all 1, ad=0, dio_a high-Z, rd_valid=0, rd_data=0, wait counter=0.
REQ-030 Reset during any operation aborts it immediately (asynchronously); no rd_valid is produced for the aborted read, and the aborted write leaves memory content undefined.
REQ-031 Requests presented while rst_n=0 are ignored; the first accept is possible on the first rising edge after rst_n rises.

Configuration
REQ-032 Macro SRAM_CTRL_BE_EN defined: ports req_be and be_n exist; on writes be_n = ~req_be (registered at accept) for WR_SETUP..WR_HOLD; on reads be_n is all 0; be_n is all 1 in IDLE.
REQ-033 Macro SRAM_CTRL_BE_EN undefined: ports req_be and be_n are absent, and every write updates all DW bits.

Verification
REQ-034 Reset release then write addr 0x00010 with data 0xA5C3 (WAIT_CYC=2) -> we_n low for exactly 2 clocks; dio_a = 0xA5C3 from WR_SETUP through WR_HOLD; req_ready low for 4 clocks.
REQ-035 Read addr 0x00010 after REQ-034 -> rd_valid pulses 3 clocks after accept with rd_data = 0xA5C3; oe_n low for 2 clocks.
REQ-036 Read immediately followed by write (req_valid held high) -> at least 1 cycle with oe_n=1 and dio_a high-Z between the two operations; no cycle with oe_n=0 while dio_a is driven.
REQ-037 With SRAM_CTRL_BE_EN: write 0xFFFF to addr 5, then write 0x1234 with req_be=2'b01, then read addr 5 -> rd_data = 0xFF34.
REQ-038 rst_n asserted in the second RD_ACC cycle -> all strobes return to 1 asynchronously, no rd_valid pulse, and req_ready=1 with the controller in IDLE after rst_n is released.
REQ-039 WAIT_CYC=15, AW=20, DW=32: 100 random reads and writes against a behavioural SRAM model -> every read returns the last data written to that address.
